// File: rtl/case_9_mul_pipe_sat.sv
// Pipelined signed/unsigned multiplier with valid/ready backpressure.
// The product is wrapped or saturated to dout_WIDTH and flagged on overflow.
module case_9_mul_pipe_sat #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 15,
  parameter int din1_WIDTH = 4,
  parameter int dout_WIDTH = 16,
  parameter int SAT        = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  sgn0,
  input  logic                  sgn1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  ovf
);

  localparam int P  = din0_WIDTH + din1_WIDTH + 2;
  localparam int DW = dout_WIDTH;
  // Working width always has at least one guard bit above the result.
  localparam int WW = (P > DW) ? P : DW + 1;
  localparam logic [DW-1:0] SMAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SMIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] UMAX = '1;

  if (NUM_STAGE < 1 || NUM_STAGE > 8 || ID < 0) begin : g_bad_cfg
    $error("NUM_STAGE must be in 1..8 and ID non-negative");
  end

  function automatic logic [DW:0] reduce_res(input logic signed [P-1:0] p,
                                             input logic sf);
    logic signed [WW-1:0] w;
    logic [WW-DW:0]       top_s;
    logic [WW-DW-1:0]     top_u;
    logic                 o;
    logic [DW-1:0]        d;
    if (sf) w = WW'(p);
    else    w = WW'($unsigned(p));
    top_s = w[WW-1:DW-1];
    top_u = w[WW-1:DW];
    o = sf ? !((&top_s) | ~(|top_s)) : (|top_u);
    d = w[DW-1:0];
    if (SAT != 0 && o) begin
      if (sf) d = w[WW-1] ? SMIN : SMAX;
      else    d = UMAX;
    end
    return {o, d};
  endfunction

  logic                         adv;
  logic signed [din0_WIDTH:0]   a_x;
  logic signed [din1_WIDTH:0]   b_x;
  logic signed [P-1:0]          prod_c;
  logic                         sflag_c;
  logic                         vld_c;
  logic signed [P-1:0]          red_p;
  logic                         red_s;
  logic                         red_v;
  logic [DW:0]                  red_r;
  logic                         out_valid_q, out_valid_d;
  logic [DW-1:0]                dout_q, dout_d;
  logic                         ovf_q, ovf_d;

  assign adv      = !out_valid_q | out_ready;
  assign in_ready = adv;

  // stage 1 input: operand extension and exact multiply
  always_comb begin
    a_x     = {sgn0 & din0[din0_WIDTH-1], din0};
    b_x     = {sgn1 & din1[din1_WIDTH-1], din1};
    prod_c  = P'(a_x) * P'(b_x);
    sflag_c = sgn0 | sgn1;
    vld_c   = in_valid & adv;
  end

  if (NUM_STAGE == 1) begin : g_direct
    assign red_p = prod_c;
    assign red_s = sflag_c;
    assign red_v = vld_c;
  end else begin : g_pipe
    localparam int NR = NUM_STAGE - 1;
    logic signed [P-1:0] prod_q  [NR];
    logic signed [P-1:0] prod_d  [NR];
    logic                sflag_q [NR];
    logic                sflag_d [NR];
    logic [NR-1:0]       vld_q, vld_d;

    // stages 1..NUM_STAGE-1: product, signed flag and valid shift together
    always_comb begin
      prod_d  = prod_q;
      sflag_d = sflag_q;
      vld_d   = vld_q;
      if (adv) begin
        prod_d[0]  = prod_c;
        sflag_d[0] = sflag_c;
        vld_d[0]   = vld_c;
        for (int i = 1; i < NR; i++) begin
          prod_d[i]  = prod_q[i-1];
          sflag_d[i] = sflag_q[i-1];
          vld_d[i]   = vld_q[i-1];
        end
      end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) vld_q <= '0;
      else           vld_q <= vld_d;
    end

    always_ff @(posedge ap_clk) begin
      prod_q  <= prod_d;
      sflag_q <= sflag_d;
    end

    assign red_p = prod_q[NR-1];
    assign red_s = sflag_q[NR-1];
    assign red_v = vld_q[NR-1];
  end

  // final stage: reduction into the output register; bubbles leave dout untouched
  always_comb begin
    red_r       = reduce_res(red_p, red_s);
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    ovf_d       = ovf_q;
    if (adv) begin
      out_valid_d = red_v;
      if (red_v) begin
        ovf_d  = red_r[DW];
        dout_d = red_r[DW-1:0];
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_case_9_mul_pipe_sat.sv
// Bench for case_9_mul_pipe_sat: four instances (latency 3 wrap/sat, 1, 8)
// share the operand stream; a reference model feeds per-instance scoreboards.
module tb_case_9_mul_pipe_sat;
  localparam int W0 = 15;
  localparam int W1 = 4;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, in_valid, sgn0, sgn1, out_ready, iv_b;
  logic          one_c;
  logic [W0-1:0] din0;
  logic [W1-1:0] din1;
  logic [3:0]    ov_v, rdy_v, of_v;
  logic [DW-1:0] do_v [4];

  int n_chk  = 0;
  int n_fail = 0;

  assign one_c = 1'b1;
  assign iv_b  = in_valid & rdy_v[0];

  case_9_mul_pipe_sat #(.NUM_STAGE(3), .SAT(0)) u_ns3 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_v[0]),
    .din0(din0), .din1(din1), .sgn0(sgn0), .sgn1(sgn1), .out_valid(ov_v[0]),
    .out_ready(out_ready), .dout(do_v[0]), .ovf(of_v[0]));
  case_9_mul_pipe_sat #(.NUM_STAGE(3), .SAT(1)) u_ns3s (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_v[1]),
    .din0(din0), .din1(din1), .sgn0(sgn0), .sgn1(sgn1), .out_valid(ov_v[1]),
    .out_ready(out_ready), .dout(do_v[1]), .ovf(of_v[1]));
  case_9_mul_pipe_sat #(.NUM_STAGE(1), .SAT(0)) u_ns1 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(iv_b), .in_ready(rdy_v[2]),
    .din0(din0), .din1(din1), .sgn0(sgn0), .sgn1(sgn1), .out_valid(ov_v[2]),
    .out_ready(one_c), .dout(do_v[2]), .ovf(of_v[2]));
  case_9_mul_pipe_sat #(.NUM_STAGE(8), .SAT(0)) u_ns8 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(iv_b), .in_ready(rdy_v[3]),
    .din0(din0), .din1(din1), .sgn0(sgn0), .sgn1(sgn1), .out_valid(ov_v[3]),
    .out_ready(one_c), .dout(do_v[3]), .ovf(of_v[3]));

  // Integer reference: exact product, range test, then wrap or clamp.
  function automatic logic [DW:0] model(input logic [W0-1:0] a, input logic [W1-1:0] b,
                                        input logic s0, input logic s1, input bit sat);
    longint av, bv, p, lo, hi;
    logic o;
    logic [DW-1:0] d;
    if (s0) av = longint'($signed(a)); else av = longint'(a);
    if (s1) bv = longint'($signed(b)); else bv = longint'(b);
    p = av * bv;
    if (s0 | s1) begin
      hi = (longint'(1) << (DW - 1)) - 1;
      lo = -(hi + 1);
    end else begin
      hi = (longint'(1) << DW) - 1;
      lo = 0;
    end
    o = (p > hi) || (p < lo);
    d = p[DW-1:0];
    if (sat && o) d = (p > hi) ? hi[DW-1:0] : lo[DW-1:0];
    return {o, d};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  logic [DW:0] sb [4][$];
  string       nm [4] = '{"ns3", "ns3sat", "ns1", "ns8"};

  // Scoreboard: push on acceptance, pop and compare on consumption.
  always @(negedge clk) begin : mon
    logic [DW:0] e;
    logic        acc, cons;
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        cons = ov_v[k] & ((k < 2) ? out_ready : 1'b1);
        if (cons) begin
          n_chk++;
          if (sb[k].size() == 0) begin
            n_fail++;
            $display("FAIL sb_%s unexpected result: got 0x%0h, expected none", nm[k], do_v[k]);
          end else begin
            e = sb[k].pop_front();
            if ({of_v[k], do_v[k]} !== e) begin
              n_fail++;
              $display("FAIL sb_%s: got ovf=%0b dout=0x%0h, expected ovf=%0b dout=0x%0h",
                       nm[k], of_v[k], do_v[k], e[DW], e[DW-1:0]);
            end
          end
        end
      end
      for (int k = 0; k < 4; k++) begin
        acc = ((k < 2) ? in_valid : iv_b) & rdy_v[k];
        if (acc) sb[k].push_back(model(din0, din1, sgn0, sgn1, k == 1));
      end
    end
  end

  typedef struct {
    logic [W0-1:0] a;
    logic [W1-1:0] b;
    logic          s0, s1;
    logic [DW-1:0] d0;
    logic          o0;
    logic [DW-1:0] d1;
    logic          o1;
  } vec_t;

  vec_t tbl [11];

  initial begin : watchdog
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1);
  end

  initial begin : main
    int t;
    int first_i, last_i, idx;
    int lat [4];
    logic [DW-1:0] got [$];

    tbl[0]  = '{15'd100,   4'hD, 1'b1, 1'b1, 16'hFED4, 1'b0, 16'hFED4, 1'b0};
    tbl[1]  = '{15'h4000,  4'h8, 1'b1, 1'b1, 16'h0000, 1'b1, 16'h7FFF, 1'b1};
    tbl[2]  = '{15'h7FFF,  4'hF, 1'b0, 1'b0, 16'h7FF1, 1'b1, 16'hFFFF, 1'b1};
    tbl[3]  = '{15'h7FFE,  4'hF, 1'b1, 1'b0, 16'hFFE2, 1'b0, 16'hFFE2, 1'b0};
    tbl[4]  = '{15'h4000,  4'h7, 1'b1, 1'b1, 16'h4000, 1'b1, 16'h8000, 1'b1};
    tbl[5]  = '{15'h0100,  4'h3, 1'b0, 1'b0, 16'h0300, 1'b0, 16'h0300, 1'b0};
    tbl[6]  = '{15'h7FFF,  4'hF, 1'b0, 1'b1, 16'h8001, 1'b0, 16'h8001, 1'b0};
    tbl[7]  = '{15'h3FFF,  4'h2, 1'b1, 1'b1, 16'h7FFE, 1'b0, 16'h7FFE, 1'b0};
    tbl[8]  = '{15'h4000,  4'h8, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h8000, 1'b1};
    tbl[9]  = '{15'h0000,  4'hF, 1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b0};
    tbl[10] = '{15'h7FFF,  4'hF, 1'b1, 1'b1, 16'h0001, 1'b0, 16'h0001, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; din0 = '0; din1 = '0;
    sgn0 = 1'b0; sgn1 = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_out_valid_%s", nm[k]), 32'(ov_v[k]), 32'd0);
      chk($sformatf("rst_dout_%s", nm[k]), 32'(do_v[k]), 32'd0);
      chk($sformatf("rst_ovf_%s", nm[k]), 32'(of_v[k]), 32'd0);
    end
    @(posedge clk); #3 rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 4; k++) chk($sformatf("idle_in_ready_%s", nm[k]), 32'(rdy_v[k]), 32'd1);

    // Directed vectors, one at a time, checked against table constants.
    for (int i = 0; i < 11; i++) begin
      @(posedge clk); #1;
      din0 = tbl[i].a; din1 = tbl[i].b; sgn0 = tbl[i].s0; sgn1 = tbl[i].s1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      t = 0;
      while (!ov_v[0] && t < 20) begin
        @(posedge clk); #1;
        t++;
      end
      chk($sformatf("tbl%0d_latency", i), 32'(t), 32'd2);
      chk($sformatf("tbl%0d_dout_wrap", i), 32'(do_v[0]), 32'(tbl[i].d0));
      chk($sformatf("tbl%0d_ovf_wrap", i), 32'(of_v[0]), 32'(tbl[i].o0));
      chk($sformatf("tbl%0d_dout_sat", i), 32'(do_v[1]), 32'(tbl[i].d1));
      chk($sformatf("tbl%0d_ovf_sat", i), 32'(of_v[1]), 32'(tbl[i].o1));
    end
    repeat (12) @(posedge clk);

    // Backpressure: 1..10 times 2 streamed with a 5-cycle consumer stall.
    @(posedge clk); #1;
    first_i = -1; last_i = -1;
    fork
      begin
        for (int i = 1; i <= 10; i++) begin
          din0 = W0'(i); din1 = 4'd2; sgn0 = 1'b1; sgn1 = 1'b1; in_valid = 1'b1;
          t = 0;
          @(negedge clk);
          while (!rdy_v[0] && t < 20) begin
            @(negedge clk);
            t++;
          end
          if (t >= 20) chk("bp_accept_timeout", 32'(t), 32'd0);
          @(posedge clk); #1;
        end
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        for (idx = 0; idx < 40; idx++) begin
          @(negedge clk);
          if (ov_v[0] && !out_ready) chk("bp_in_ready_low", 32'(rdy_v[0]), 32'd0);
          if (ov_v[0] && out_ready) begin
            got.push_back(do_v[0]);
            if (first_i < 0) first_i = idx;
            last_i = idx;
          end
        end
      end
    join
    chk("bp_count", 32'(got.size()), 32'd10);
    for (int i = 0; i < got.size(); i++)
      chk($sformatf("bp_val%0d", i), 32'(got[i]), 32'(2 * (i + 1)));
    chk("bp_span", 32'(last_i - first_i), 32'd14);
    repeat (12) @(posedge clk);

    // Reset with beats in flight, then nominal latency for the next beat.
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      din0 = W0'(5 + i); din1 = 4'd3; sgn0 = 1'b1; sgn1 = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("midrst_out_valid_%s", nm[k]), 32'(ov_v[k]), 32'd0);
      chk($sformatf("midrst_dout_%s", nm[k]), 32'(do_v[k]), 32'd0);
      chk($sformatf("midrst_ovf_%s", nm[k]), 32'(of_v[k]), 32'd0);
      sb[k].delete();
    end
    @(posedge clk); @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    din0 = 15'd9; din1 = 4'hE; sgn0 = 1'b1; sgn1 = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) lat[k] = 0;
    for (int c = 1; c <= 12; c++) begin
      for (int k = 0; k < 4; k++) if (ov_v[k] && lat[k] == 0) lat[k] = c;
      @(posedge clk); #1;
    end
    chk("post_rst_latency_ns3", 32'(lat[0]), 32'd3);
    chk("post_rst_latency_ns3sat", 32'(lat[1]), 32'd3);
    chk("post_rst_latency_ns1", 32'(lat[2]), 32'd1);
    chk("post_rst_latency_ns8", 32'(lat[3]), 32'd8);

    repeat (12) @(posedge clk);
    for (int k = 0; k < 4; k++) chk($sformatf("drain_%s", nm[k]), 32'(sb[k].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/case_9_mul_pipe_sat.md
Name: case_9_mul_pipe_sat

Overview:
- Pipelined, parametrised successor to the HLS combinational multiplier cores.
- Multiplies two operands with per-transaction signed/unsigned selection.
- Pipeline depth is configurable, with a valid/ready handshake and backpressure stall.
- The product is either wrapped or saturated to the output width, with an overflow flag.
- Used where the scheduler needs a registered multiplier that can stall with the downstream consumer.

Parameters:
ID, 1, instance tag; no functional effect
NUM_STAGE, 3, pipeline latency in cycles; legal range 1..8
din0_WIDTH, 15, width of operand 0
din1_WIDTH, 4, width of operand 1
dout_WIDTH, 16, width of result
SAT, 0, 0 = wrap (truncate), 1 = saturate on overflow

Ports:
ap_clk  in  1  clock; all state updates on rising edge
ap_rst_n  in  1  reset; asynchronous assert, active-low
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept a beat this cycle
din0  in  din0_WIDTH  operand 0
din1  in  din1_WIDTH  operand 1
sgn0  in  1  1 = din0 is two's complement, 0 = unsigned
sgn1  in  1  1 = din1 is two's complement, 0 = unsigned
out_valid  out  1  result beat valid
out_ready  in  1  consumer accepts the result
dout  out  dout_WIDTH  result
ovf  out  1  result lost information (wrapped or clamped); qualified by out_valid

Behaviour:
- Reset (ap_rst_n = 0, asynchronous) clears:
  - all stage valid bits;
  - out_valid = 0, dout = 0, ovf = 0.
- in_ready is combinational: in_ready = !out_valid | out_ready. It is 1 while in reset-released idle.
- Stall/advance:
  - adv = !out_valid | out_ready.
  - When adv = 1, every stage shifts by one. Stage 1 loads valid = in_valid & in_ready.
  - When adv = 0, all stages and outputs hold.
  - Bubbles are not compacted.
- A beat is accepted when in_valid & in_ready. A result is consumed when out_valid & out_ready.
- Latency: with no stall, a beat accepted at edge k appears at out_valid/dout after edge k+NUM_STAGE-1 (registered at stage 1 on edge k). Throughput is 1 beat/cycle.
- Arithmetic (stage 1):
  - Each operand is extended by 1 bit: sign-extended if its sgnX = 1, else zero-extended.
  - Full product width P = din0_WIDTH + din1_WIDTH + 2. The signed multiply of the extended operands is exact.
  - The result is interpreted as signed when sgn0 | sgn1, else unsigned; this flag travels with the beat.
- Reduction (final stage):
  - signed, P > dout_WIDTH: ovf = 1 when bits [P-1:dout_WIDTH-1] are not all equal.
  - unsigned: ovf = 1 when bits [P-1:dout_WIDTH] are not all zero.
  - if P <= dout_WIDTH: the result is sign/zero-extended and ovf = 0.
  - SAT = 0: dout = low dout_WIDTH bits.
  - SAT = 1 with ovf: signed clamps to 2^(dout_WIDTH-1)-1 or -2^(dout_WIDTH-1) by the product sign; unsigned clamps to 2^dout_WIDTH-1.
- NUM_STAGE = 1: multiply and reduction happen in the same registered stage.
- Intermediate stages carry data, the signed flag and the valid bit. Data registers need no reset; valid bits do.
- Ordering: results leave in acceptance order; no beat is dropped or duplicated under any stall pattern.
- Reset mid-operation: all in-flight beats are discarded. The first beat accepted after release emerges with the nominal latency.
- Simultaneous consume and accept in one cycle is legal and sustains full rate.

Test Plan:
1. Signed basic, SAT=0: din0 = 100, din1 = -3 (0xD), sgn0 = sgn1 = 1 -> after 3 cycles dout = 0xFED4 (-300), ovf = 0.
2. Signed overflow: din0 = -16384 (0x4000), din1 = -8 (0x8), both signed.
   - SAT=0 -> dout = 0x0000, ovf = 1.
   - SAT=1 -> dout = 0x7FFF, ovf = 1.
3. Unsigned: din0 = 0x7FFF, din1 = 0xF, sgn0 = sgn1 = 0 (product 491505).
   - SAT=0 -> dout = 0x7FF1, ovf = 1.
   - SAT=1 -> dout = 0xFFFF, ovf = 1.
4. Mixed: din0 = 0x7FFE signed (-2), din1 = 0xF unsigned (15) -> dout = 0xFFE2 (-30), ovf = 0.
5. Backpressure: stream operands 1..10 times 2 (signed) continuously, with out_ready held 0 for 5 cycles mid-stream.
   - in_ready drops while out_valid = 1 and out_ready = 0.
   - Outputs are exactly 2, 4, ..., 20, in order, with no loss.
   - Full rate recovers after release.
6. Reset mid-flight: accept 3 beats, pull ap_rst_n low between edges.
   - out_valid = 0 and dout = 0 immediately.
   - After release, a new beat emerges NUM_STAGE cycles later; no stale beat appears.
   - Repeat with NUM_STAGE = 1 and NUM_STAGE = 8.
